inst_loader: RTL and testbench

//  Writer side of the CPU instruction memory: accepts instruction fields (op, src1, src2, dest)

---
 rtl/inst_loader.sv | 140 ++++++++++++++
 tb/tb_inst_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// Instruction memory writer: buffers packed instruction fields in a small FIFO and
// drains them one word per cycle into consecutive instruction memory addresses.
module inst_loader #(
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned MEM_WORDS  = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [1:0]        in_src1,
    input  logic [1:0]        in_src2,
    input  logic [1:0]        in_dest,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   word_count
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = 9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t             state;
    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               last_seen;
    logic [ADDR_W-1:0]  wr_addr;

    logic               fifo_full;
    logic               fifo_empty;
    logic               accept;
    logic               pop;
    logic [ENTRY_W-1:0] head;
    logic [7:0]         packed_word;

    assign packed_word = {in_op, in_src1, in_src2, in_dest};
    assign fifo_full   = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty  = (count == '0);
    assign head        = fifo_mem[rd_ptr];

    // Ready depends only on registered state, never on in_valid.
    assign in_ready = (state == S_LOAD) && !fifo_full && !last_seen;
    assign busy     = (state == S_LOAD);
    assign accept   = in_valid && in_ready;
    assign pop      = (state == S_LOAD) && !fifo_empty;

    // FIFO storage: entry = {packed instruction, last flag}.
    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_mem[wr_ptr] <= {packed_word, in_last};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            last_seen  <= 1'b0;
            wr_addr    <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            word_count <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_LOAD;
                        rd_ptr     <= '0;
                        wr_ptr     <= '0;
                        count      <= '0;
                        last_seen  <= 1'b0;
                        wr_addr    <= '0;
                        done       <= 1'b0;
                        overflow   <= 1'b0;
                        word_count <= '0;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        wr_ptr <= wr_ptr + PTR_W'(1);
                        if (in_last) begin
                            last_seen <= 1'b1;
                        end
                    end
                    if (accept && !pop) begin
                        count <= count + CNT_W'(1);
                    end else if (!accept && pop) begin
                        count <= count - CNT_W'(1);
                    end
                    if (pop) begin
                        rd_ptr     <= rd_ptr + PTR_W'(1);
                        mem_we     <= 1'b1;
                        mem_addr   <= wr_addr;
                        mem_wdata  <= head[ENTRY_W-1:1];
                        word_count <= word_count + (ADDR_W+1)'(1);
                        if (head[0]) begin
                            state   <= S_DONE;
                            done    <= 1'b1;
                            wr_addr <= wr_addr + ADDR_W'(1);
                        end else if (wr_addr == ADDR_W'(MEM_WORDS - 1)) begin
                            // Program too long: keep the final write, drop the rest.
                            state    <= S_DONE;
                            done     <= 1'b1;
                            overflow <= 1'b1;
                            rd_ptr   <= '0;
                            wr_ptr   <= '0;
                            count    <= '0;
                        end else begin
                            wr_addr <= wr_addr + ADDR_W'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: random programs compared against a
// transaction-level model (each accepted word is written exactly one edge later).
module tb_inst_loader;

    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned MEM_WORDS = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_op;
    logic [1:0]        in_src1;
    logic [1:0]        in_src2;
    logic [1:0]        in_dest;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [ADDR_W:0]   word_count;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  words [64];
    logic [7:0]  first_wdata;

    inst_loader #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_src1(in_src1), .in_src2(in_src2), .in_dest(in_dest),
        .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .overflow(overflow), .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_word(input logic [7:0] w, input logic last);
        in_op   = w[7:6];
        in_src1 = w[5:4];
        in_src2 = w[3:2];
        in_dest = w[1:0];
        in_last = last;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},    32'(mem_we),     32'd0);
        check({tag, "_addr"},  32'(mem_addr),   32'd0);
        check({tag, "_wdata"}, 32'(mem_wdata),  32'd0);
        check({tag, "_busy"},  32'(busy),       32'd0);
        check({tag, "_done"},  32'(done),       32'd0);
        check({tag, "_ovf"},   32'(overflow),   32'd0);
        check({tag, "_wc"},    32'(word_count), 32'd0);
        check({tag, "_rdy"},   32'(in_ready),   32'd0);
    endtask

    // One program load: n words (last flag on word n-1 if with_last), valid asserted with
    // probability vpct%, optional start pulse at loop cycle mid_start.
    task automatic run_load(input int n, input bit with_last, input int vpct, input int mid_start);
        int         sent    = 0;
        int         pending = -1;
        int         written = 0;
        int         cyc     = 0;
        bit         ended   = 0;
        bit         last_acc = 0;
        bit         exp_ovf = 0;
        bit         exp_ready;
        bit         fire;
        logic [7:0] w;

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_done", 32'(done), 32'd0);
        check("start_ovf",  32'(overflow), 32'd0);
        check("start_wc",   32'(word_count), 32'd0);

        while (!ended && cyc < 400) begin
            exp_ready = !last_acc;
            check("in_ready", 32'(in_ready), 32'(exp_ready));
            fire = ((sent < n) || last_acc) && ($urandom_range(99) < 32'(vpct));
            w = (sent < n) ? words[sent] : 8'($urandom);
            in_valid = fire;
            drive_word(w, with_last && (sent == n - 1));
            start = (cyc == mid_start);
            @(posedge clk);
            #1;
            if (pending >= 0) begin
                check("we",    32'(mem_we),    32'd1);
                check("addr",  32'(mem_addr),  32'(written));
                check("wdata", 32'(mem_wdata), 32'(words[pending]));
                if (written == 0) first_wdata = mem_wdata;
                written++;
                if (with_last && pending == n - 1) begin
                    ended = 1;
                end else if (written == MEM_WORDS) begin
                    ended   = 1;
                    exp_ovf = 1;
                end
            end else begin
                check("we_idle", 32'(mem_we), 32'd0);
            end
            check("word_count", 32'(word_count), 32'(written));
            pending = -1;
            if (fire && exp_ready) begin
                if (!ended) pending = sent;
                if (in_last) last_acc = 1;
                sent++;
            end
            @(negedge clk);
            start = 1'b0;
            in_valid = 1'b0;
            cyc++;
        end
        if (!ended) check("load_timeout", 32'd0, 32'd1);

        check("end_done",  32'(done),       32'd1);
        check("end_ovf",   32'(overflow),   32'(exp_ovf));
        check("end_busy",  32'(busy),       32'd0);
        check("end_rdy",   32'(in_ready),   32'd0);
        check("end_wc",    32'(word_count), 32'(written));

        // Stray input in DONE must have no effect.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            drive_word(8'($urandom), 1'b0);
            @(posedge clk);
            #1;
            check("done_we", 32'(mem_we),     32'd0);
            check("done_wc", 32'(word_count), 32'(written));
            check("done_hold", 32'(done),     32'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        drive_word(8'h00, 1'b0);
        first_wdata = 8'h00;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        // Input while IDLE is ignored.
        in_valid = 1'b1;
        drive_word(8'hA5, 1'b1);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("idle_we",  32'(mem_we),     32'd0);
            check("idle_wc",  32'(word_count), 32'd0);
            check("idle_rdy", 32'(in_ready),   32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;

        // Directed three-word program, first word op=1 src1=2 src2=3 dest=0.
        words[0] = {2'd1, 2'd2, 2'd3, 2'd0};
        words[1] = 8'($urandom);
        words[2] = 8'($urandom);
        run_load(3, 1'b1, 100, -1);
        check("first_wdata", 32'(first_wdata), 32'h6C);

        // Six words at full rate.
        for (int i = 0; i < 6; i++) words[i] = 8'($urandom);
        run_load(6, 1'b1, 100, -1);

        // Overflow: 17 words without last.
        for (int i = 0; i < 17; i++) words[i] = 8'($urandom);
        run_load(17, 1'b0, 100, -1);

        // Exactly MEM_WORDS with last: no overflow.
        for (int i = 0; i < 16; i++) words[i] = 8'($urandom);
        run_load(16, 1'b1, 100, -1);

        // start pulsed mid-load is ignored.
        for (int i = 0; i < 5; i++) words[i] = 8'($urandom);
        run_load(5, 1'b1, 100, 2);

        // Random gappy programs.
        for (int k = 0; k < 4; k++) begin
            int n;
            n = int'($urandom_range(16, 1));
            for (int i = 0; i < n; i++) words[i] = 8'($urandom);
            run_load(n, 1'b1, 60, -1);
        end
        for (int i = 0; i < 24; i++) words[i] = 8'($urandom);
        run_load(24, 1'b0, 70, -1);

        // Reset in the middle of a load.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_word(8'($urandom), 1'b0);
            @(negedge clk);
        end
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("post_reset_we",   32'(mem_we), 32'd0);
            check("post_reset_busy", 32'(busy),   32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;

        // Recovery load after reset.
        for (int i = 0; i < 4; i++) words[i] = 8'($urandom);
        run_load(4, 1'b1, 100, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
